// File: rtl/shared_add_pkg.sv
// shared_add_pkg: state encoding, nibble width and nibble-count helper for the shared adder scheduler
package shared_add_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/shared_adder_sched_nibble_adder.sv
// nibble_adder: combinational 4-bit ripple adder with carry in/out
module nibble_adder
  import shared_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  assign {cout, sum} = a + b + cin;
endmodule

// File: rtl/shared_adder_sched.sv
// shared_adder_sched: round-robin two-requester scheduler around one time-shared nibble adder
module shared_adder_sched
  import shared_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  localparam int NIB = nib_count(WIDTH);
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("shared_adder_sched: WIDTH must be a positive multiple of 4");
  end
  state_t state, state_nx;
  logic ptr, id, carry, grant0, grant1, last, nib_cout;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, sum;
  logic [NIBBLE_W-1:0] nib_sum;
  assign grant1 = req1_valid && (!req0_valid || ptr);
  assign grant0 = req0_valid && !grant1;
  assign req0_ready = rst_n && state == IDLE && grant0;
  assign req1_ready = rst_n && state == IDLE && grant1;
  assign last = cnt == CW'(NIB - 1);
  nibble_adder u_nib (
    .a   (op_a[int'(cnt)*NIBBLE_W +: NIBBLE_W]),
    .b   (op_b[int'(cnt)*NIBBLE_W +: NIBBLE_W]),
    .cin (carry),
    .sum (nib_sum),
    .cout(nib_cout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((grant0 || grant1) ? ADD : IDLE) :
               state == ADD  ? (last ? DONE : ADD) :
               (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr   <= 1'b0;
      id    <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      sum   <= '0;
    end else if (state == IDLE && (grant0 || grant1)) begin
      op_a  <= grant1 ? req1_a : req0_a;
      op_b  <= grant1 ? req1_b : req0_b;
      carry <= grant1 ? req1_cin : req0_cin;
      id    <= grant1;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == ADD) begin
      sum[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= nib_sum;
      carry <= nib_cout;
      cnt   <= cnt + 1'b1;
    end else if (state == DONE && rsp_ready) begin
      ptr <= !id;
    end
  assign rsp_valid = state == DONE;
  assign busy      = state != IDLE;
  assign rsp_sum   = sum;
  assign rsp_cout  = carry;
  assign rsp_id    = id;
endmodule
